ay_sf_sincos_s_axi_regs: RTL
============================

# ay_sf_sincos_s_axi_regs

AXI4-Lite slave register file for the sincos IP. It is the responder that the block-design master VIPs drive with single-beat writes and reads. It holds four 32-bit read/write registers, exports them to the sincos datapath, and emits a one-cycle commit pulse per register write. One instance sits behind each S0x_AXI port of the IP.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses bits [3:2].

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg0_o..reg3_o  out  32 each  current register contents.
- wr_pulse_o  out  4  bit k high for one cycle on the commit of a write to reg k.

## Operation
- Register k is at byte offset 4k. AWADDR[1:0] and ARADDR[1:0] are ignored, so unaligned addresses alias to the enclosing word.
- **Write channel** is two independent capture slots (AW, W) plus a response stage:
  - AWREADY = registered, high when the AW slot is empty and BVALID is low.
  - WREADY = registered, high when the W slot is empty and BVALID is low.
  - AW and W may arrive in either order or in the same cycle; each is held until the other arrives.
  - **Commit** happens on the edge after both slots are full: only bytes with WSTRB[b]=1 are updated; both slots clear; wr_pulse_o[k] is high for that one cycle; BVALID rises.
  - BVALID holds until BREADY. No new AW or W is accepted while BVALID is high.
- **Read channel** has states IDLE and RESP:
  - IDLE: ARREADY=1. On ARVALID, RDATA is loaded from the addressed register, RVALID=1, and the state moves to RESP.
  - RESP: ARREADY=0. RDATA and RVALID are held until RREADY, then the state returns to IDLE.
- **Read/write collision:** the read samples the register on its AR handshake edge. A commit on that same edge is not visible, so the read returns the old value. A later read returns the new value.
- Read and write channels run concurrently; neither stalls the other.

## Timing
- **Reset values** (asynchronous, immediate on ARESETN=0):
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - RDATA = 0, reg0..3 = 0, wr_pulse_o = 0, BRESP = RRESP = 0.
- AWREADY, WREADY and ARREADY rise on the first S_AXI_ACLK edge after ARESETN is released.
- **Write latency:** AW and W handshakes at edge N → register updated, wr_pulse_o high and BVALID high after edge N+1. With BREADY held high, BVALID drops after N+2. Minimum write throughput is one write every 3 cycles.
- If AW handshakes at edge N and W at edge N+j, the commit occurs at edge N+j+1.
- **Read latency:** AR handshake at edge N → RVALID high after edge N. With RREADY held high, the next AR can be accepted at edge N+2 (one read every 2 cycles).
- **Backpressure:** BREADY or RREADY held low for M cycles holds BVALID/RVALID and the data stable for those M cycles.
- **Reset mid-transaction:** half-captured AW/W slots and pending B/R responses are discarded. No commit and no wr_pulse occur.

## Test plan
- **Sequential write/readback:** after reset, write 1,2,3,4 to offsets 0x0,0x4,0x8,0xC with WSTRB=0xF, then read back → RDATA 1,2,3,4; all BRESP/RRESP=0; wr_pulse_o pulses 0001,0010,0100,1000, one cycle each.
- **Byte strobes:** reg1=0x11223344, then write 0xAABBCCDD with WSTRB=0101 → readback 0x11BB33DD, and reg1_o shows the same value.
- **Channel ordering:** W presented 3 cycles before AW, then AW before W, then both together → each commits exactly once, on the edge after the second handshake; BVALID stays asserted until BREADY while BREADY is held low for 5 cycles.
- **Collision:** AR to 0x8 on the same edge as the commit of 0x5A5A5A5A to reg2 (old value 0x3) → RDATA=0x3; the next read returns 0x5A5A5A5A.
- **Read backpressure:** RREADY low for 4 cycles → RVALID and RDATA stable and ARREADY=0 throughout; the next AR is accepted only after the R handshake.
- **Reset mid-write:** AW accepted, W not yet, then ARESETN pulsed low → no BVALID; all registers read 0; wr_pulse_o never asserted.

Source files
------------

// File: rtl/ay_sf_sincos_s_axi_regs.sv
// ay_sf_sincos_s_axi_regs: AXI4-Lite slave with four 32-bit registers, commit pulses and independent AW/W capture slots.
module ay_sf_sincos_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      wr_pulse_o
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {IDLE, RESP} rd_state_t;

    rd_state_t                     rd_state;
    logic                          aw_full, w_full, commit, aw_full_n, w_full_n, bvalid_n;
    logic [1:0]                    aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]                 w_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic                          unused;

    assign unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign reg0_o      = regs[0];
    assign reg1_o      = regs[1];
    assign reg2_o      = regs[2];
    assign reg3_o      = regs[3];

    // Slots fill on handshake and both empty on the commit edge that follows.
    always_comb begin
        commit    = aw_full & w_full;
        aw_full_n = ~commit & (aw_full | (S_AXI_AWVALID & S_AXI_AWREADY));
        w_full_n  = ~commit & (w_full | (S_AXI_WVALID & S_AXI_WREADY));
        bvalid_n  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            wr_pulse_o    <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_full       <= aw_full_n;
            w_full        <= w_full_n;
            S_AXI_BVALID  <= bvalid_n;
            S_AXI_AWREADY <= ~aw_full_n & ~bvalid_n;
            S_AXI_WREADY  <= ~w_full_n & ~bvalid_n;
            wr_pulse_o    <= commit ? 4'b0001 << aw_idx : 4'b0000;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_idx <= S_AXI_AWADDR[3:2];
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit)
                for (int b = 0; b < NB; b++)
                    if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    // A commit on the AR edge is not visible: regs still holds the old value here.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state      <= IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else if (rd_state == IDLE) begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RDATA   <= regs[S_AXI_ARADDR[3:2]];
                S_AXI_RVALID  <= 1'b1;
                S_AXI_ARREADY <= 1'b0;
                rd_state      <= RESP;
            end else begin
                S_AXI_ARREADY <= 1'b1;
            end
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rd_state      <= IDLE;
        end
    end
endmodule
